instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum idle cycles between bytes of a partial word (used only under REQ-030).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port inStart, input, 1, level-sampled request to begin a load.
REQ-007 SHALL have port inRxData, input, 8, received byte.
REQ-008 SHALL have port inRxValid, input, 1, single-cycle strobe qualifying inRxData.
REQ-009 SHALL have port outDataInstruction, output, 32, assembled instruction to memory write data.
REQ-010 SHALL have port outWrInstruction, output, 1, one-cycle memory write strobe.
REQ-011 SHALL have port outWrAddr, output, 32, word address of the current write.
REQ-012 SHALL have port outStopPC, output, 1, holds pipeline PC while no valid program is loaded.
REQ-013 SHALL have port outWordCount, output, 32, words written in the current load.
REQ-014 SHALL have port outDone, output, 1, load completed with HALT_WORD.
REQ-015 SHALL have port outError, output, 1, overflow or timeout.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, DONE, ERROR.
REQ-017 IDLE -> LOAD when inStart=1; inRxValid ignored in IDLE.
REQ-018 In LOAD, each inRxValid byte SHALL be shifted into a 32-bit assembler, big-endian: first byte -> [31:24], fourth -> [7:0].
REQ-019 On acceptance of the fourth byte, outDataInstruction SHALL load the assembled word and outWrInstruction SHALL pulse high for exactly the next cycle, with outWrAddr equal to the pre-increment outWordCount.
REQ-020 outWordCount SHALL increment in the same cycle as the outWrInstruction pulse; outDataInstruction and outWrAddr SHALL remain stable until the next write.
REQ-021 Bytes arriving during the write-pulse cycle SHALL be accepted without loss; byte-counter wraps 3 -> 0.
REQ-022 If the written word equals HALT_WORD it SHALL still be written; the FSM SHALL then enter DONE on the write cycle.
REQ-023 If the write with outWrAddr = MAX_WORDS-1 is not HALT_WORD, FSM SHALL enter ERROR; no write to address MAX_WORDS ever occurs.
REQ-024 inStart during LOAD SHALL be ignored.
REQ-025 From DONE or ERROR, inStart=1 SHALL clear outWordCount, byte counter, outDone, outError and enter LOAD next cycle.
REQ-026 outStopPC SHALL be 1 in IDLE, LOAD and ERROR, 0 only in DONE.
REQ-027 outDone=1 only in DONE; outError=1 only in ERROR.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, outStopPC=1, and all other outputs, counters and assembler to 0, independent of clk.
REQ-029 Reset asserted mid-word or mid-write pulse SHALL abort the load; a subsequent load restarts at address 0.

Configuration
REQ-030 With macro INSTRUCTION_LOADER_TIMEOUT_EN defined, a cycle counter SHALL clear on every accepted byte and, when byte counter != 0 in LOAD and the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ERROR; without the macro no counter is synthesized and LOAD waits indefinitely.

Verification
REQ-031 Reset, inStart, bytes 20 01 00 05 -> one write pulse, data 0x20010005, addr 0, outWordCount 1, outStopPC 1.
REQ-032 Load 3 words then FF FF FF FF -> writes at addr 0..3, addr 3 data 0xFFFFFFFF, outDone=1, outStopPC=0.
REQ-033 MAX_WORDS=4, 16 non-halt bytes -> 4 writes, outError=1, no fifth write, outStopPC=1.
REQ-034 Bytes on consecutive cycles (inRxValid held 8 cycles) -> 2 writes, no byte lost, data matches.
REQ-035 rst=0 after 2 bytes of a word, release, restart with 4 bytes -> write at addr 0 with only the new bytes.
REQ-036 TIMEOUT_EN, TIMEOUT_CYCLES=10, 1 byte then 10 idle cycles -> outError=1; without macro -> remains in LOAD.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: receives a byte stream, assembles big-endian 32-bit
// instruction words and writes them into instruction memory. The load ends
// in DONE when HALT_WORD is written, or in ERROR when the memory fills up.
// The pipeline PC is held until a complete program has been loaded.
// Optional feature: define INSTRUCTION_LOADER_TIMEOUT_EN to abort a load
// when a partial word sits idle for TIMEOUT_CYCLES cycles.
module instruction_loader #(
    parameter int          MAX_WORDS      = 256,
    parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inStart,
    input  logic [7:0]  inRxData,
    input  logic        inRxValid,
    output logic [31:0] outDataInstruction,
    output logic        outWrInstruction,
    output logic [31:0] outWrAddr,
    output logic        outStopPC,
    output logic [31:0] outWordCount,
    output logic        outDone,
    output logic        outError
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    // Only the three oldest bytes need holding; the fourth arrives live.
    logic [23:0] asm_q, asm_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] count_q, count_d;
    logic        wr_q, wr_d;

    logic        byte_acc;
    logic [31:0] new_word;

    assign byte_acc = (state_q == S_LOAD) && inRxValid;
    assign new_word = {asm_q, inRxData};

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle-cycle counter register for the partial-word timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
        end
    end

    // Next-state and next-datapath logic: byte assembly, write issue, end-of-load
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wr_d       = 1'b0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (inStart) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    count_d    = '0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
                    idle_d     = '0;
`endif
                end
            end
            S_LOAD: begin
                if (byte_acc) begin
                    asm_d      = {asm_q[15:0], inRxData};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes a word: write it at the current count.
                        data_d  = new_word;
                        addr_d  = count_q;
                        count_d = count_q + 32'd1;
                        wr_d    = 1'b1;
                        // Halt takes priority over overflow on the last slot.
                        if (new_word == HALT_WORD) begin
                            state_d = S_DONE;
                        end else if (count_q == 32'(MAX_WORDS - 1)) begin
                            state_d = S_ERROR;
                        end
                    end
                end
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
                if (byte_acc || (byte_cnt_q == 2'd0)) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_d  = '0;
                    state_d = S_ERROR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            S_DONE, S_ERROR: begin
                if (inStart) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    count_d    = '0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
                    idle_d     = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        outStopPC = 1'b1;
        outDone   = 1'b0;
        outError  = 1'b0;
        unique case (state_q)
            S_DONE:  begin
                outStopPC = 1'b0;
                outDone   = 1'b1;
            end
            S_ERROR: outError = 1'b1;
            default: begin
                outStopPC = 1'b1;
            end
        endcase
    end

    assign outDataInstruction = data_q;
    assign outWrInstruction   = wr_q;
    assign outWrAddr          = addr_q;
    assign outWordCount       = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: randomized byte stream, reference model
// of the loader built from byte/word queues, and a scoreboard monitor that
// checks every memory write as it appears.
module tb_instruction_loader;

    localparam int          MAXW = 4;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inStart = 1'b0;
    logic [7:0]  inRxData = 8'h00;
    logic        inRxValid = 1'b0;
    logic [31:0] outDataInstruction;
    logic        outWrInstruction;
    logic [31:0] outWrAddr;
    logic        outStopPC;
    logic [31:0] outWordCount;
    logic        outDone;
    logic        outError;

    instruction_loader #(
        .MAX_WORDS      (MAXW),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .inStart            (inStart),
        .inRxData           (inRxData),
        .inRxValid          (inRxValid),
        .outDataInstruction (outDataInstruction),
        .outWrInstruction   (outWrInstruction),
        .outWrAddr          (outWrAddr),
        .outStopPC          (outStopPC),
        .outWordCount       (outWordCount),
        .outDone            (outDone),
        .outError           (outError)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Reference model state
    bit          m_load;
    bit          m_done;
    bit          m_err;
    int          m_count;
    logic [7:0]  m_buf[$];
    logic [31:0] m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_load  = 0;
        m_done  = 0;
        m_err   = 0;
        m_count = 0;
        m_last  = '0;
        m_buf.delete();
    endfunction

    function automatic void m_start();
        if (!m_load) begin
            m_load  = 1;
            m_done  = 0;
            m_err   = 0;
            m_count = 0;
            m_buf.delete();
        end
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_load) begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                exp_q.push_back('{addr: 32'(m_count), data: w});
                m_last = w;
                m_count++;
                m_buf.delete();
                if (w == HALT) begin
                    m_load = 0;
                    m_done = 1;
                end else if (m_count == MAXW) begin
                    m_load = 0;
                    m_err  = 1;
                end
            end
        end
    endfunction

    // A partial word left idle long enough aborts the load when the timeout is built in.
    function automatic void m_long_idle();
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        if (m_load && m_buf.size() != 0) begin
            m_load = 0;
            m_err  = 1;
            m_buf.delete();
        end
`endif
    endfunction

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst && outWrInstruction) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h required no write",
                         outWrAddr, outDataInstruction);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0d data=%h count=%0d", outWrAddr, outDataInstruction, outWordCount);
                chk("wr_addr", outWrAddr, e.addr);
                chk("wr_data", outDataInstruction, e.data);
                chk("wr_count", outWordCount, e.addr + 32'd1);
            end
        end
    end

    task automatic start_cyc();
        @(posedge clk);
        #1;
        inStart   = 1'b1;
        inRxValid = 1'b0;
        m_start();
    endtask

    task automatic byte_cyc(input logic [7:0] b);
        @(posedge clk);
        #1;
        inStart   = 1'b0;
        inRxValid = 1'b1;
        inRxData  = b;
        m_byte(b);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            inStart   = 1'b0;
            inRxValid = 1'b0;
            inRxData  = 8'($urandom);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            byte_cyc(w[31-8*i -: 8]);
            if (gap > 0) idle_cyc(gap);
        end
    endtask

    task automatic check_status(input string tag);
        idle_cyc(1);
        @(negedge clk);
        $display("status %s: count=%0d done=%0b error=%0b stoppc=%0b", tag,
                 outWordCount, outDone, outError, outStopPC);
        chk({tag, "_count"}, outWordCount, 32'(m_count));
        chk({tag, "_done"}, 32'(outDone), 32'(m_done));
        chk({tag, "_error"}, 32'(outError), 32'(m_err));
        chk({tag, "_stoppc"}, 32'(outStopPC), 32'(!m_done));
        chk({tag, "_data_hold"}, outDataInstruction, m_last);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst       = 1'b0;
        inStart   = 1'b0;
        inRxValid = 1'b0;
        #1;
        m_reset();
        $display("reset applied");
        chk("rst_stoppc", 32'(outStopPC), 32'd1);
        chk("rst_wr", 32'(outWrInstruction), 32'd0);
        chk("rst_data", outDataInstruction, 32'd0);
        chk("rst_addr", outWrAddr, 32'd0);
        chk("rst_count", outWordCount, 32'd0);
        chk("rst_done", 32'(outDone), 32'd0);
        chk("rst_error", 32'(outError), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : stimulus
        logic [31:0] w;
        m_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Single word after start; stray start/valid in IDLE must not matter
        byte_cyc(8'hAB);
        idle_cyc(1);
        start_cyc();
        idle_cyc(1);
        send_word(32'h20010005, 2);
        check_status("single_word");

        // Start pulse in the middle of a word is ignored while loading
        byte_cyc(8'h11);
        byte_cyc(8'h22);
        start_cyc();
        byte_cyc(8'h33);
        byte_cyc(8'h44);
        check_status("start_in_load");

        // Three words then halt lands exactly on the last slot: DONE wins
        do_reset();
        start_cyc();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            send_word(w, int'($urandom_range(0, 2)));
        end
        send_word(HALT, 1);
        check_status("halt_done");
        send_word(32'h01020304, 0);
        check_status("done_ignores_bytes");

        // Overflow: four non-halt words fill memory, further bytes never write
        start_cyc();
        for (int i = 0; i < MAXW; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            send_word(w, int'($urandom_range(0, 1)));
        end
        check_status("overflow");
        send_word(32'hCAFEF00D, 0);
        check_status("error_no_fifth");

        // Back-to-back bytes: valid held for eight cycles
        start_cyc();
        for (int i = 0; i < 8; i++) byte_cyc(8'($urandom));
        check_status("back_to_back");

        // Reset mid-word, then a fresh load restarts at address zero
        byte_cyc(8'h99);
        byte_cyc(8'h88);
        do_reset();
        start_cyc();
        send_word(32'h0BADBEEF, 0);
        check_status("reset_mid_word");

        // Partial word followed by a long idle stretch
        byte_cyc(8'h5A);
        idle_cyc(12);
        m_long_idle();
        check_status("long_idle");
        byte_cyc(8'h6B);
        byte_cyc(8'h7C);
        byte_cyc(8'h8D);
        check_status("after_idle");

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 5) == 0) do_reset();
            start_cyc();
            for (int k = 0, n = int'($urandom_range(1, 5)); k < n; k++) begin
                w = ($urandom_range(0, 4) == 0) ? HALT : $urandom;
                for (int i = 0; i < 4; i++) begin
                    byte_cyc(w[31-8*i -: 8]);
                    idle_cyc(int'($urandom_range(0, 2)));
                    if ($urandom_range(0, 9) == 0) start_cyc();
                end
            end
            check_status($sformatf("rand%0d", r));
        end

        idle_cyc(3);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
